// File: rtl/tls_pkg.sv
// Shared types and constants for the intersection scheduler: state encoding,
// lamp patterns and the state-to-lamp decode.
package tls_pkg;

    typedef enum logic [2:0] {
        S_MGRN = 3'd0,
        S_MYEL = 3'd1,
        S_ARED = 3'd2,
        S_WALK = 3'd3,
        S_CGRN = 3'd4,
        S_CYEL = 3'd5,
        S_EMRG = 3'd6
    } state_e;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    typedef struct packed {
        logic [2:0] main_lamp;
        logic [2:0] cross_lamp;
        logic       walk_lamp;
    } lamps_t;

    // Any encoding outside the defined states shows all-red with walk off.
    function automatic lamps_t decode_lamps(input state_e st);
        lamps_t l;
        case (st)
            S_MGRN:  l = '{main_lamp: LAMP_GRN, cross_lamp: LAMP_RED, walk_lamp: 1'b0};
            S_MYEL:  l = '{main_lamp: LAMP_YEL, cross_lamp: LAMP_RED, walk_lamp: 1'b0};
            S_ARED:  l = '{main_lamp: LAMP_RED, cross_lamp: LAMP_RED, walk_lamp: 1'b0};
            S_WALK:  l = '{main_lamp: LAMP_RED, cross_lamp: LAMP_RED, walk_lamp: 1'b1};
            S_CGRN:  l = '{main_lamp: LAMP_RED, cross_lamp: LAMP_GRN, walk_lamp: 1'b0};
            S_CYEL:  l = '{main_lamp: LAMP_RED, cross_lamp: LAMP_YEL, walk_lamp: 1'b0};
            S_EMRG:  l = '{main_lamp: LAMP_RED, cross_lamp: LAMP_RED, walk_lamp: 1'b0};
            default: l = '{main_lamp: LAMP_RED, cross_lamp: LAMP_RED, walk_lamp: 1'b0};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/intersection_scheduler_tick_gen.sv
// Free-running tick divider: tick is high for one clk cycle every TICK_DIV cycles.
module tick_gen #(
    parameter int unsigned TICK_DIV = 32'd50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 32'd1) ? $clog2(TICK_DIV) : 32'd1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 32'd1);

    logic [CW-1:0] cnt_r;

    assign tick = (cnt_r == CNT_LAST);

    // Divider counter, wraps to zero after the tick cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

endmodule

// File: rtl/intersection_scheduler.sv
// Junction phase scheduler: one Moore FSM sequencing main, cross and walk phases.
// Build option: define TLC_EMERG_EN to enable emergency preemption.
module intersection_scheduler
    import tls_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 32'd50_000_000,
    parameter int unsigned MIN_GREEN   = 32'd5,
    parameter int unsigned YELLOW_T    = 32'd3,
    parameter int unsigned ALLRED_T    = 32'd1,
    parameter int unsigned CROSS_GREEN = 32'd10,
    parameter int unsigned WALK_T      = 32'd7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       veh_req,
    input  logic       ped_req,
    input  logic       emerg,
    output logic [2:0] light_main,
    output logic [2:0] light_cross,
    output logic       walk,
    output logic       veh_ack,
    output logic       ped_ack,
    output logic [2:0] phase
);

    localparam logic [3:0] MGRN_LAST = 4'(MIN_GREEN - 32'd1);
    localparam logic [3:0] YEL_LAST  = 4'(YELLOW_T - 32'd1);
    localparam logic [3:0] ARED_LAST = 4'(ALLRED_T - 32'd1);
    localparam logic [3:0] CGRN_LAST = 4'(CROSS_GREEN - 32'd1);
    localparam logic [3:0] WALK_LAST = 4'(WALK_T - 32'd1);

    logic       tick_s;
    logic       emerg_s;
    state_e     state_r;
    state_e     state_nxt_s;
    logic [3:0] timer_r;
    logic       veh_pend_r;
    logic       ped_pend_r;
    logic       last_side_r;
    logic       last_side_nxt_s;
    logic       veh_ack_r;
    logic       ped_ack_r;
    logic       cgrn_entry_s;
    logic       walk_entry_s;
    lamps_t     lamps_s;

`ifdef TLC_EMERG_EN
    assign emerg_s = emerg;
`else
    logic unused_emerg_s;
    assign unused_emerg_s = emerg;
    assign emerg_s        = 1'b0;
`endif

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick_s)
    );

    assign cgrn_entry_s = (state_nxt_s == S_CGRN) && (state_r != S_CGRN);
    assign walk_entry_s = (state_nxt_s == S_WALK) && (state_r != S_WALK);

    // Next-state and last-served-road selection.
    always_comb begin
        state_nxt_s     = state_r;
        last_side_nxt_s = last_side_r;
        case (state_r)
            S_MGRN: begin
                // Main green may sit past its minimum; the timer saturates so a late request still exits on a tick.
                if (emerg_s) begin
                    state_nxt_s = S_MYEL;
                end else if (tick_s && (timer_r >= MGRN_LAST) && (veh_pend_r || ped_pend_r)) begin
                    state_nxt_s = S_MYEL;
                end else begin
                    state_nxt_s = S_MGRN;
                end
            end
            S_MYEL: begin
                if (tick_s && (timer_r == YEL_LAST)) begin
                    state_nxt_s     = S_ARED;
                    last_side_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = S_MYEL;
                end
            end
            S_ARED: begin
                if (!(tick_s && (timer_r == ARED_LAST))) begin
                    state_nxt_s = S_ARED;
                end else if (emerg_s) begin
                    state_nxt_s = S_EMRG;
                end else if (ped_pend_r) begin
                    state_nxt_s = S_WALK;
                end else if (!last_side_r && veh_pend_r) begin
                    state_nxt_s = S_CGRN;
                end else begin
                    state_nxt_s = S_MGRN;
                end
            end
            S_WALK: begin
                if (emerg_s) begin
                    state_nxt_s = S_EMRG;
                end else if (tick_s && (timer_r == WALK_LAST)) begin
                    state_nxt_s = S_MGRN;
                end else begin
                    state_nxt_s = S_WALK;
                end
            end
            S_CGRN: begin
                if (emerg_s || (tick_s && (timer_r == CGRN_LAST))) begin
                    state_nxt_s = S_CYEL;
                end else begin
                    state_nxt_s = S_CGRN;
                end
            end
            S_CYEL: begin
                if (tick_s && (timer_r == YEL_LAST)) begin
                    state_nxt_s     = S_ARED;
                    last_side_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = S_CYEL;
                end
            end
            S_EMRG: begin
                if (emerg_s) begin
                    state_nxt_s = S_EMRG;
                end else begin
                    state_nxt_s = S_MGRN;
                end
            end
            default: begin
                state_nxt_s = S_MGRN;
            end
        endcase
    end

    // State, phase timer and last-served-road registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_MGRN;
            timer_r     <= 4'd0;
            last_side_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            last_side_r <= last_side_nxt_s;
            if (state_nxt_s != state_r) begin
                timer_r <= 4'd0;
            end else if (tick_s && (timer_r != 4'hF)) begin
                timer_r <= timer_r + 4'd1;
            end else begin
                timer_r <= timer_r;
            end
        end
    end

    // Request latches and service acks; a new request in the service-entry cycle stays pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            veh_pend_r <= 1'b0;
            ped_pend_r <= 1'b0;
            veh_ack_r  <= 1'b0;
            ped_ack_r  <= 1'b0;
        end else begin
            veh_pend_r <= veh_req | (veh_pend_r & ~cgrn_entry_s);
            ped_pend_r <= ped_req | (ped_pend_r & ~walk_entry_s);
            veh_ack_r  <= cgrn_entry_s;
            ped_ack_r  <= walk_entry_s;
        end
    end

    assign lamps_s     = decode_lamps(state_r);
    assign light_main  = lamps_s.main_lamp;
    assign light_cross = lamps_s.cross_lamp;
    assign walk        = lamps_s.walk_lamp;
    assign veh_ack     = veh_ack_r;
    assign ped_ack     = ped_ack_r;
    assign phase       = state_r;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Directed self-checking bench for intersection_scheduler with TICK_DIV=4 (one tick = 4 cycles).
module tb_intersection_scheduler;
    import tls_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       veh_req = 1'b0;
    logic       ped_req = 1'b0;
    logic       emerg = 1'b0;
    logic [2:0] light_main;
    logic [2:0] light_cross;
    logic       walk;
    logic       veh_ack;
    logic       ped_ack;
    logic [2:0] phase;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    intersection_scheduler #(
        .TICK_DIV (32'd4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .veh_req     (veh_req),
        .ped_req     (ped_req),
        .emerg       (emerg),
        .light_main  (light_main),
        .light_cross (light_cross),
        .walk        (walk),
        .veh_ack     (veh_ack),
        .ped_ack     (ped_ack),
        .phase       (phase)
    );

    // Reset released on a negedge: tick counter and timer start at zero from there.
    task automatic do_reset();
        veh_req = 1'b0;
        ped_req = 1'b0;
        emerg   = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Counts negedges until phase leaves its current value (bounded by maxc).
    task automatic hold_len(input int maxc, output int n);
        logic [2:0] cur;
        cur = phase;
        n = 0;
        while (phase === cur && n < maxc) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic pulse_req(input logic v, input logic p);
        repeat (2) @(negedge clk);
        veh_req = v;
        ped_req = p;
        @(negedge clk);
        veh_req = 1'b0;
        ped_req = 1'b0;
    endtask

    task automatic test_reset();
        veh_req = 1'b0; ped_req = 1'b0; emerg = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if ({light_main, light_cross, walk, veh_ack, ped_ack, phase} !== {3'b001, 3'b100, 1'b0, 1'b0, 1'b0, 3'd0}) begin errors++; $display("FAIL reset_vals: got %b/%b w%b va%b pa%b ph%0d, expected 001/100 w0 va0 pa0 ph0", light_main, light_cross, walk, veh_ack, ped_ack, phase); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            checks++; if (phase !== 3'd0 || light_main !== 3'b001 || light_cross !== 3'b100 || walk !== 1'b0 || veh_ack !== 1'b0 || ped_ack !== 1'b0) begin errors++; $display("FAIL idle_cycle %0d: got ph%0d %b/%b w%b va%b pa%b, expected ph0 001/100 w0 va0 pa0", i, phase, light_main, light_cross, walk, veh_ack, ped_ack); end
        end
    endtask

    task automatic test_vehicle();
        int n;
        do_reset();
        pulse_req(1'b1, 1'b0);
        hold_len(100, n);
        checks++; if (n + 3 !== 20 || phase !== 3'd1 || light_main !== 3'b010) begin errors++; $display("FAIL veh_mgrn: got %0d cycles ph%0d main %b, expected 20 ph1 main 010", n + 3, phase, light_main); end
        hold_len(100, n);
        checks++; if (n !== 12 || phase !== 3'd2 || light_main !== 3'b100 || light_cross !== 3'b100) begin errors++; $display("FAIL veh_myel: got %0d ph%0d %b/%b, expected 12 ph2 100/100", n, phase, light_main, light_cross); end
        hold_len(100, n);
        checks++; if (n !== 4 || phase !== 3'd4 || light_cross !== 3'b001 || veh_ack !== 1'b1) begin errors++; $display("FAIL veh_ared: got %0d ph%0d cross %b ack %b, expected 4 ph4 cross 001 ack 1", n, phase, light_cross, veh_ack); end
        @(negedge clk);
        checks++; if (veh_ack !== 1'b0) begin errors++; $display("FAIL veh_ack_pulse: got %b, expected 0", veh_ack); end
        hold_len(100, n);
        checks++; if (n + 1 !== 40 || phase !== 3'd5 || light_cross !== 3'b010) begin errors++; $display("FAIL veh_cgrn: got %0d ph%0d cross %b, expected 40 ph5 cross 010", n + 1, phase, light_cross); end
        hold_len(100, n);
        checks++; if (n !== 12 || phase !== 3'd2) begin errors++; $display("FAIL veh_cyel: got %0d ph%0d, expected 12 ph2", n, phase); end
        hold_len(100, n);
        checks++; if (n !== 4 || phase !== 3'd0 || light_main !== 3'b001) begin errors++; $display("FAIL veh_ared2: got %0d ph%0d main %b, expected 4 ph0 main 001", n, phase, light_main); end
        hold_len(60, n);
        checks++; if (n !== 60 || phase !== 3'd0) begin errors++; $display("FAIL veh_cleared: got %0d ph%0d, expected 60 ph0", n, phase); end
    endtask

    task automatic test_pedestrian();
        int n;
        do_reset();
        pulse_req(1'b0, 1'b1);
        hold_len(100, n);
        checks++; if (n + 3 !== 20 || phase !== 3'd1) begin errors++; $display("FAIL ped_mgrn: got %0d ph%0d, expected 20 ph1", n + 3, phase); end
        hold_len(100, n);
        hold_len(100, n);
        checks++; if (n !== 4 || phase !== 3'd3 || walk !== 1'b1 || ped_ack !== 1'b1 || light_main !== 3'b100 || light_cross !== 3'b100) begin errors++; $display("FAIL ped_walk_entry: got %0d ph%0d w%b pa%b %b/%b, expected 4 ph3 w1 pa1 100/100", n, phase, walk, ped_ack, light_main, light_cross); end
        @(negedge clk);
        checks++; if (ped_ack !== 1'b0 || walk !== 1'b1) begin errors++; $display("FAIL ped_ack_pulse: got pa%b w%b, expected pa0 w1", ped_ack, walk); end
        hold_len(100, n);
        checks++; if (n + 1 !== 28 || phase !== 3'd0 || walk !== 1'b0 || light_main !== 3'b001 || light_cross !== 3'b100) begin errors++; $display("FAIL ped_walk_len: got %0d ph%0d w%b %b/%b, expected 28 ph0 w0 001/100", n + 1, phase, walk, light_main, light_cross); end
    endtask

    task automatic test_both();
        int n;
        do_reset();
        pulse_req(1'b1, 1'b1);
        hold_len(100, n);
        hold_len(100, n);
        hold_len(100, n);
        checks++; if (phase !== 3'd3 || ped_ack !== 1'b1 || veh_ack !== 1'b0) begin errors++; $display("FAIL both_walk_first: got ph%0d pa%b va%b, expected ph3 pa1 va0", phase, ped_ack, veh_ack); end
        hold_len(100, n);
        checks++; if (n !== 28 || phase !== 3'd0) begin errors++; $display("FAIL both_walk_len: got %0d ph%0d, expected 28 ph0", n, phase); end
        hold_len(100, n);
        checks++; if (n !== 20 || phase !== 3'd1) begin errors++; $display("FAIL both_mgrn: got %0d ph%0d, expected 20 ph1", n, phase); end
        hold_len(100, n);
        hold_len(100, n);
        checks++; if (n !== 4 || phase !== 3'd4 || veh_ack !== 1'b1) begin errors++; $display("FAIL both_cgrn: got %0d ph%0d va%b, expected 4 ph4 va1", n, phase, veh_ack); end
    endtask

    task automatic test_emergency();
        int n;
        do_reset();
        pulse_req(1'b1, 1'b0);
        hold_len(100, n);
        hold_len(100, n);
        hold_len(100, n);
        repeat (16) @(negedge clk);
        emerg = 1'b1;
        hold_len(100, n);
`ifdef TLC_EMERG_EN
        checks++; if (n !== 1 || phase !== 3'd5) begin errors++; $display("FAIL emg_cgrn_exit: got %0d ph%0d, expected 1 ph5", n, phase); end
        hold_len(100, n);
        checks++; if (n !== 11 || phase !== 3'd2) begin errors++; $display("FAIL emg_cyel_len: got %0d ph%0d, expected 11 ph2", n, phase); end
        hold_len(100, n);
        checks++; if (n !== 4 || phase !== 3'd6 || light_main !== 3'b100 || light_cross !== 3'b100) begin errors++; $display("FAIL emg_enter: got %0d ph%0d %b/%b, expected 4 ph6 100/100", n, phase, light_main, light_cross); end
        hold_len(80, n);
        checks++; if (n !== 80 || phase !== 3'd6) begin errors++; $display("FAIL emg_hold: got %0d ph%0d, expected 80 ph6", n, phase); end
        emerg = 1'b0;
        @(negedge clk);
        checks++; if (phase !== 3'd0 || light_main !== 3'b001) begin errors++; $display("FAIL emg_release: got ph%0d main %b, expected ph0 main 001", phase, light_main); end
`else
        checks++; if (n + 16 !== 40 || phase !== 3'd5) begin errors++; $display("FAIL noemg_cgrn: got %0d ph%0d, expected 40 ph5", n + 16, phase); end
        hold_len(100, n);
        hold_len(100, n);
        checks++; if (n !== 4 || phase !== 3'd0) begin errors++; $display("FAIL noemg_ared: got %0d ph%0d, expected 4 ph0", n, phase); end
        hold_len(40, n);
        checks++; if (n !== 40 || phase !== 3'd0) begin errors++; $display("FAIL noemg_mgrn_hold: got %0d ph%0d, expected 40 ph0", n, phase); end
        emerg = 1'b0;
`endif
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        pulse_req(1'b1, 1'b0);
        hold_len(100, n);
        hold_len(100, n);
        hold_len(100, n);
        hold_len(100, n);
        checks++; if (phase !== 3'd5) begin errors++; $display("FAIL rstmid_cyel: got ph%0d, expected ph5", phase); end
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (light_main !== 3'b001 || light_cross !== 3'b100 || walk !== 1'b0 || phase !== 3'd0) begin errors++; $display("FAIL rstmid_async: got %b/%b w%b ph%0d, expected 001/100 w0 ph0", light_main, light_cross, walk, phase); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        hold_len(80, n);
        checks++; if (n !== 80 || phase !== 3'd0 || walk !== 1'b0) begin errors++; $display("FAIL rstmid_no_service: got %0d ph%0d w%b, expected 80 ph0 w0", n, phase, walk); end
    endtask

    initial begin
        test_reset();
        test_vehicle();
        test_pedestrian();
        test_both();
        test_emergency();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/intersection_scheduler.md
# intersection_scheduler

Phase scheduler for one two-road junction with pedestrian crossing and emergency preemption. Shares the junction between three requesters: cross-road vehicle sensor, pedestrian push-button and emergency-vehicle input. Drives the main and cross signal heads and the walk lamp from a single Moore FSM. All phase durations come from an internal 1 s tick divider.

## Interface
- TICK_DIV, 50_000_000: clk cycles per tick (1 s at 50 MHz); a bench uses 4
- MIN_GREEN, 5: minimum main-green ticks before yielding
- YELLOW_T, 3: yellow ticks (both roads)
- ALLRED_T, 1: all-red clearance ticks
- CROSS_GREEN, 10: cross-green ticks
- WALK_T, 7: pedestrian walk ticks
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- veh_req  in  1  cross-road vehicle sensor, level; any high cycle latches a request
- ped_req  in  1  pedestrian button, level; any high cycle latches a request
- emerg  in  1  emergency preempt, level, not latched
- light_main  out  3  {red,yellow,green} one-hot
- light_cross  out  3  {red,yellow,green} one-hot
- walk  out  1  walk lamp
- veh_ack  out  1  one-cycle pulse on entry to S_CGRN
- ped_ack  out  1  one-cycle pulse on entry to S_WALK
- phase  out  3  current state encoding

## Operation
- Tick: counter 0..TICK_DIV-1; tick=1 on the cycle where counter==TICK_DIV-1, then wraps to 0.
- Phase timer: 4 bits. Cleared on every state change. Increments on tick. A timed state exits on the cycle where tick=1 and timer==DUR-1. All durations are 1..15.
- Pending flags veh_pend and ped_pend:
  - Set by the corresponding request input.
  - Cleared on entry to S_CGRN and S_WALK respectively.
  - When set and clear coincide, set wins.
- Register last_side records the road whose green ended: 0=main, 1=cross.
- States, with light_main/light_cross/walk in that order:
  - S_MGRN=0 (001/100/0): stays while timer<MIN_GREEN-1 or nothing pending. Exits to S_MYEL on the exit tick when veh_pend, ped_pend or emerg is set. emerg also forces S_MYEL on the next clock regardless of timer.
  - S_MYEL=1 (010/100/0): YELLOW_T ticks, then S_ARED with last_side=0.
  - S_ARED=2 (100/100/0): ALLRED_T ticks, then the first of:
    - emerg → S_EMRG
    - ped_pend → S_WALK
    - last_side=0 and veh_pend → S_CGRN
    - otherwise S_MGRN
  - S_WALK=3 (100/100/1): WALK_T ticks, then S_MGRN. emerg aborts to S_EMRG on the next clock.
  - S_CGRN=4 (100/001/0): CROSS_GREEN ticks, then S_CYEL. emerg exits to S_CYEL on the next clock.
  - S_CYEL=5 (100/010/0): YELLOW_T ticks, then S_ARED with last_side=1.
  - S_EMRG=6 (100/100/0): held while emerg=1. When emerg falls, S_MGRN on the next clock.
  - Encoding 7: S_MGRN on the next clock.
- Yellow and all-red phases are never shortened, including by emerg.
- Outputs are decoded combinationally from the state register. Acks are registered pulses aligned with the first cycle in the new state.

## Timing
- Reset values:
  - state S_MGRN, light_main=001, light_cross=100
  - walk=0, veh_ack=0, ped_ack=0, phase=0
  - pending flags, last_side, timer and tick counter all 0
- Request input to pending flag: 1 cycle.
- emerg to leaving S_MGRN, S_CGRN or S_WALK: 1 cycle.
- A timed state lasts between DUR-1 and DUR tick periods after entry; from S_MGRN entry it is exact, since the tick counter is free-running.
- Reset asserted mid-phase: all outputs take reset values immediately (asynchronous); operation resumes in S_MGRN with timer=0.

## Configuration
- TLC_EMERG_EN defined: emergency preemption as described above.
- Not defined:
  - emerg port is present but ignored.
  - S_EMRG is unreachable, and every emerg term evaluates to 0.

## Structure
- Package tls_pkg holds:
  - the state typedef/localparams S_MGRN..S_EMRG
  - lamp constants LAMP_RED=3'b100, LAMP_YEL=3'b010, LAMP_GRN=3'b001
- Sub-module tick_gen(clk, rst_n, tick), parameterised by TICK_DIV. Counter width is $clog2(TICK_DIV).

## Test plan
All scenarios use TICK_DIV=4 and default durations.
- Reset, no requests for 200 cycles → state stays S_MGRN, 001/100, walk=0, no acks.
- veh_req high for 1 cycle at cycle 2 → main green for 5 ticks, S_MYEL 3 ticks, S_ARED 1 tick, then S_CGRN with veh_ack pulse for 10 ticks, S_CYEL 3, S_ARED 1, back to S_MGRN; veh_pend=0.
- ped_req pulse → after S_MYEL/S_ARED, walk=1 for 7 ticks with ped_ack on entry, then S_MGRN 001/100.
- veh_req and ped_req in the same cycle → S_WALK served first, then S_MGRN for 5 ticks, then the cross-green sequence.
- emerg rises at tick 4 of S_CGRN → S_CYEL next cycle, full 3 yellow ticks, S_ARED, S_EMRG 100/100 held for 20 ticks; emerg falls → S_MGRN next cycle. With TLC_EMERG_EN undefined, S_CGRN runs its full 10 ticks.
- rst_n low during S_CYEL, with ped_pend=1 → outputs immediately 001/100, walk=0; after release, S_MGRN with no pending service.
